me_search_ctrl: RTL and testbench

ME_SEARCH_CTRL -- requirements
Module: me_search_ctrl

---
 rtl/me_search_ctrl.sv | 161 ++++++++++++++++
 tb/tb_me_search_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/me_search_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : me_search_ctrl
// Brief    : Motion-estimation search controller. It waits for the reference
//            window, lets the SAD datapath fill, and then tracks the minimum
//            batch SAD over SEARCH_ROWS rows to report the best motion vector.
// Revision : 1.0 - initial release
// ============================================================================
module me_search_ctrl #(
  parameter int SAD_BIT_WIDTH = 14,
  parameter int SEARCH_ROWS   = 16,
  parameter int FILL_CYCLES   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic                     abort_i,
  input  logic                     sram_ready_i,
  input  logic [SAD_BIT_WIDTH-1:0] msad_i,
  input  logic [3:0]               msad_idx_i,
  output logic                     datapath_en_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [SAD_BIT_WIDTH-1:0] best_sad_o,
  output logic [3:0]               mv_x_o,
  output logic [3:0]               mv_y_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_RDY = 3'd1,
    S_FILL     = 3'd2,
    S_SEARCH   = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  localparam logic [7:0] C_FILL_LAST = 8'(FILL_CYCLES - 1);
  localparam logic [3:0] C_ROW_LAST  = 4'(SEARCH_ROWS - 1);

  state_t                   r_state;
  state_t                   w_next;
  logic [7:0]               r_fill_cnt;
  logic [3:0]               r_row;
  logic [SAD_BIT_WIDTH-1:0] r_min;
  logic [3:0]               r_min_x;
  logic [3:0]               r_min_y;
  logic [SAD_BIT_WIDTH-1:0] r_best;
  logic [3:0]               r_best_x;
  logic [3:0]               r_best_y;

  logic                     w_fill_last;
  logic                     w_row_last;
  logic                     w_sample;
  logic                     w_take;
  logic [SAD_BIT_WIDTH-1:0] w_min_nxt;
  logic [3:0]               w_x_nxt;
  logic [3:0]               w_y_nxt;

  assign w_fill_last = (r_fill_cnt == C_FILL_LAST);
  assign w_row_last  = (r_row == C_ROW_LAST);
  // An abort in the same cycle cancels the sample so a cancelled search
  // can never leak a partial result into the outputs.
  assign w_sample    = (r_state == S_SEARCH) && !abort_i;
  // Row 0 seeds the minimum; later rows replace it only when strictly
  // smaller, which keeps the earliest row on ties.
  assign w_take      = (r_row == 4'd0) || (msad_i < r_min);
  assign w_min_nxt   = w_take ? msad_i     : r_min;
  assign w_x_nxt     = w_take ? msad_idx_i : r_min_x;
  assign w_y_nxt     = w_take ? r_row      : r_min_y;

  assign best_sad_o  = r_best;
  assign mv_x_o      = r_best_x;
  assign mv_y_o      = r_best_y;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state decode and state-derived outputs; abort overrides everything
  always_comb begin
    w_next        = r_state;
    datapath_en_o = 1'b0;
    busy_o        = 1'b1;
    done_o        = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy_o = 1'b0;
        if (start_i) w_next = S_WAIT_RDY;
      end
      S_WAIT_RDY: begin
        if (sram_ready_i) w_next = S_FILL;
      end
      S_FILL: begin
        datapath_en_o = 1'b1;
        if (w_fill_last) w_next = S_SEARCH;
      end
      S_SEARCH: begin
        datapath_en_o = 1'b1;
        if (w_row_last) w_next = S_DONE;
      end
      S_DONE: begin
        done_o = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
    if (abort_i && (r_state != S_IDLE)) w_next = S_IDLE;
  end

  // Pipeline fill counter, cleared whenever FILL is not being continued
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_fill_cnt <= 8'd0;
    else if ((r_state == S_FILL) && !abort_i && !w_fill_last)
      r_fill_cnt <= r_fill_cnt + 8'd1;
    else
      r_fill_cnt <= 8'd0;
  end

  // Search row counter, advances once per sampled row
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_row <= 4'd0;
    else if (w_sample && !w_row_last)
      r_row <= r_row + 4'd1;
    else
      r_row <= 4'd0;
  end

  // Running minimum over the rows of the current block
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_min   <= '1;
      r_min_x <= 4'd0;
      r_min_y <= 4'd0;
    end else if (w_sample) begin
      r_min   <= w_min_nxt;
      r_min_x <= w_x_nxt;
      r_min_y <= w_y_nxt;
    end
  end

  // Result registers load on entry to DONE, including the final row's sample
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_best   <= '0;
      r_best_x <= 4'd0;
      r_best_y <= 4'd0;
    end else if (w_sample && w_row_last) begin
      r_best   <= w_min_nxt;
      r_best_x <= w_x_nxt;
      r_best_y <= w_y_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_me_search_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_me_search_ctrl
// Brief    : Self-checking bench for me_search_ctrl. Expected outputs are held
//            as per-cycle timelines built from each block's start/ready/abort
//            schedule, with literal checks on the key results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_me_search_ctrl;

  localparam int MAXC = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic        sram_ready_i = 1'b0;
  logic [13:0] msad_i = '0;
  logic [3:0]  msad_idx_i = '0;
  logic        datapath_en_o;
  logic        busy_o;
  logic        done_o;
  logic [13:0] best_sad_o;
  logic [3:0]  mv_x_o;
  logic [3:0]  mv_y_o;

  me_search_ctrl #(
    .SAD_BIT_WIDTH(14),
    .SEARCH_ROWS  (16),
    .FILL_CYCLES  (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .sram_ready_i (sram_ready_i),
    .msad_i       (msad_i),
    .msad_idx_i   (msad_idx_i),
    .datapath_en_o(datapath_en_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .best_sad_o   (best_sad_o),
    .mv_x_o       (mv_x_o),
    .mv_y_o       (mv_y_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected per-cycle timelines
  logic        e_busy [MAXC];
  logic        e_den  [MAXC];
  logic        e_done [MAXC];
  logic [13:0] e_best [MAXC];
  logic [3:0]  e_x    [MAXC];
  logic [3:0]  e_y    [MAXC];

  logic [13:0] msad_tab [16];
  logic [3:0]  idx_tab  [16];

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int den_cnt = 0;
  int last_done_cyc = -1;
  int last_ready = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_result_from(input int c, input logic [13:0] b, input logic [3:0] x,
                                 input logic [3:0] y);
    for (int i = c; i < MAXC; i++) begin
      e_best[i] = b;
      e_x[i]    = x;
      e_y[i]    = y;
    end
  endtask

  // Winner = smallest value over all rows, earliest row among equals
  task automatic model_min(output logic [13:0] b, output logic [3:0] x, output logic [3:0] y);
    int  m;
    bit  found;
    m = 32'h7fff_ffff;
    for (int r = 0; r < 16; r++)
      if (int'(msad_tab[r]) < m) m = int'(msad_tab[r]);
    found = 1'b0;
    b = '0; x = '0; y = '0;
    for (int r = 0; r < 16; r++) begin
      if (!found && int'(msad_tab[r]) == m) begin
        found = 1'b1;
        b = msad_tab[r];
        x = idx_tab[r];
        y = 4'(r);
      end
    end
  endtask

  // One block: start now, ready 'pre' cycles later; optional abort on a row,
  // stray start pulses during FILL / DONE, abort asserted together with start.
  task automatic run_block(input int pre, input int abort_row, input bit st_fill,
                           input bit st_done, input bit ab_start);
    int s, r, a, last;
    logic [13:0] b;
    logic [3:0]  x, y;
    s = cyc;
    r = s + pre;
    a = (abort_row >= 0) ? (r + 9 + abort_row) : -1;
    last = (abort_row >= 0) ? a : (r + 25);
    last_ready = r;
    done_cnt = 0;
    den_cnt = 0;
    for (int c = s + 1; c <= last; c++) e_busy[c] = 1'b1;
    for (int c = r + 1; c <= ((abort_row >= 0) ? a : (r + 24)); c++) e_den[c] = 1'b1;
    if (abort_row < 0) begin
      e_done[r + 25] = 1'b1;
      model_min(b, x, y);
      set_result_from(r + 25, b, x, y);
    end
    for (int c = s; c <= last + 1; c++) begin
      start_i      = (c == s) || (st_fill && c == r + 3) ||
                     (st_done && abort_row < 0 && c == r + 25);
      abort_i      = (c == a) || (ab_start && c == s);
      sram_ready_i = (c == r);
      if (c >= r + 9 && c <= r + 24) begin
        msad_i     = msad_tab[c - r - 9];
        msad_idx_i = idx_tab[c - r - 9];
      end else begin
        msad_i     = '0;
        msad_idx_i = '0;
      end
      tick();
    end
    start_i = 0; abort_i = 0; sram_ready_i = 0; msad_i = '0; msad_idx_i = '0;
  endtask

  // Start a block, pull reset low during FILL, then pulse ready with no start
  task automatic run_reset_fill();
    int s, r, f;
    s = cyc;
    r = s + 2;
    f = r + 4;
    done_cnt = 0;
    for (int c = s + 1; c < f; c++) e_busy[c] = 1'b1;
    for (int c = r + 1; c < f; c++) e_den[c] = 1'b1;
    set_result_from(f, '0, '0, '0);
    for (int c = s; c <= f + 10; c++) begin
      start_i      = (c == s);
      sram_ready_i = (c == r) || (c == f + 5);
      rst          = !(c == f || c == f + 1);
      if (c == f) begin
        #1;
        chk("rst_busy", {31'd0, busy_o}, 0);
        chk("rst_den", {31'd0, datapath_en_o}, 0);
        chk("rst_best", {18'd0, best_sad_o}, 0);
        chk("rst_mv", {24'd0, mv_x_o, mv_y_o}, 0);
      end
      tick();
    end
    start_i = 0; sram_ready_i = 0; rst = 1;
    chk("rst_no_done", done_cnt, 0);
  endtask

  // Per-cycle comparison against the timelines, plus activity monitors
  initial begin
    forever begin
      @(negedge clk);
      if (cyc < MAXC) begin
        chk("busy_o", {31'd0, busy_o}, {31'd0, e_busy[cyc]});
        chk("datapath_en_o", {31'd0, datapath_en_o}, {31'd0, e_den[cyc]});
        chk("done_o", {31'd0, done_o}, {31'd0, e_done[cyc]});
        chk("best_sad_o", {18'd0, best_sad_o}, {18'd0, e_best[cyc]});
        chk("mv_x_o", {28'd0, mv_x_o}, {28'd0, e_x[cyc]});
        chk("mv_y_o", {28'd0, mv_y_o}, {28'd0, e_y[cyc]});
        if (done_o) begin
          done_cnt++;
          last_done_cyc = cyc;
        end
        if (datapath_en_o) den_cnt++;
      end
    end
  end

  initial begin
    for (int i = 0; i < MAXC; i++) begin
      e_busy[i] = 0; e_den[i] = 0; e_done[i] = 0;
      e_best[i] = '0; e_x[i] = '0; e_y[i] = '0;
    end
    repeat (2) tick();
    chk("reset_busy", {31'd0, busy_o}, 0);
    chk("reset_done", {31'd0, done_o}, 0);
    chk("reset_best", {18'd0, best_sad_o}, 0);
    rst = 1'b1;
    repeat (2) tick();

    // Descending SADs: last row wins
    for (int r = 0; r < 16; r++) begin
      msad_tab[r] = 14'(100 - r);
      idx_tab[r]  = 4'(r);
    end
    run_block(3, -1, 0, 0, 0);
    chk("desc_best", {18'd0, best_sad_o}, 85);
    chk("desc_x", {28'd0, mv_x_o}, 15);
    chk("desc_y", {28'd0, mv_y_o}, 15);
    chk("latency", last_done_cyc - last_ready, 25);
    chk("desc_done_cnt", done_cnt, 1);
    chk("desc_den_cnt", den_cnt, 24);
    repeat (2) tick();

    // Tie on rows 3 and 9: earlier row kept
    for (int r = 0; r < 16; r++) begin
      msad_tab[r] = 14'd200;
      idx_tab[r]  = 4'((r * 5 + 1) % 16);
    end
    msad_tab[3] = 14'd50; idx_tab[3] = 4'd7;
    msad_tab[9] = 14'd50; idx_tab[9] = 4'd2;
    run_block(1, -1, 0, 0, 0);
    chk("tie_best", {18'd0, best_sad_o}, 50);
    chk("tie_x", {28'd0, mv_x_o}, 7);
    chk("tie_y", {28'd0, mv_y_o}, 3);
    repeat (2) tick();

    // Abort on row 5 (rows before it carry a smaller value than the last result)
    for (int r = 0; r < 16; r++) begin
      msad_tab[r] = 14'(10 + r);
      idx_tab[r]  = 4'(15 - r);
    end
    run_block(2, 5, 0, 0, 0);
    chk("abort_done_cnt", done_cnt, 0);
    chk("abort_best", {18'd0, best_sad_o}, 50);
    chk("abort_xy", {24'd0, mv_x_o, mv_y_o}, {24'd0, 4'd7, 4'd3});
    repeat (2) tick();

    // Stray starts in FILL and DONE, abort together with start in IDLE
    for (int r = 0; r < 16; r++) begin
      msad_tab[r] = 14'(((r * 37) % 23) + 300);
      idx_tab[r]  = 4'((r * 3) % 16);
    end
    run_block(4, -1, 1, 1, 1);
    chk("stray_done_cnt", done_cnt, 1);
    chk("stray_den_cnt", den_cnt, 24);
    chk("stray_best", {18'd0, best_sad_o}, 300);
    chk("stray_y", {28'd0, mv_y_o}, 0);
    repeat (3) tick();

    run_reset_fill();
    repeat (2) tick();

    // Maximum value on row 0, nothing smaller later
    for (int r = 0; r < 16; r++) begin
      msad_tab[r] = 14'd16383;
      idx_tab[r]  = 4'(r + 4);
    end
    idx_tab[0] = 4'd9;
    run_block(2, -1, 0, 0, 0);
    chk("max_best", {18'd0, best_sad_o}, 16383);
    chk("max_x", {28'd0, mv_x_o}, 9);
    chk("max_y", {28'd0, mv_y_o}, 0);
    chk("max_den_cnt", den_cnt, 24);
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
